// File: rtl/z_core_mul_div.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | z_core_mul_div : iterative RV32M multiply / divide unit (shift-add,        |
// | restoring divide), one result bit per cycle.  Rev 1.0                      |
// +----------------------------------------------------------------------------+
module z_core_mul_div #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            md_start,
  input  logic [2:0]      md_op,
  input  logic [XLEN-1:0] md_in1,
  input  logic [XLEN-1:0] md_in2,
  input  logic            md_kill,
  output logic            md_busy,
  output logic            md_done,
  output logic [XLEN-1:0] md_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] c_int_min = {1'b1, {(XLEN-1){1'b0}}};

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [2:0]          r_op;
  logic                r_neg;
  logic                r_bypass;
  logic [XLEN-1:0]     r_opnd;
  logic [2*XLEN-1:0]   r_acc;

  logic                w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_neg;
  logic                w_div0, w_ovf;
  logic [XLEN-1:0]     w_a_abs, w_b_abs, w_special;
  logic [XLEN:0]       w_sum, w_shift, w_diff;
  logic [2*XLEN-1:0]   w_acc_nxt, w_prod;
  logic [XLEN-1:0]     w_res;

  // Request decode: operand magnitudes, result sign and the single-cycle cases.
  always_comb begin
    w_a_signed = (md_op == 3'd1) || (md_op == 3'd2) || (md_op == 3'd4) || (md_op == 3'd6);
    w_b_signed = (md_op == 3'd1) || (md_op == 3'd4) || (md_op == 3'd6);
    w_a_neg    = w_a_signed && md_in1[XLEN-1];
    w_b_neg    = w_b_signed && md_in2[XLEN-1];
    w_a_abs    = w_a_neg ? -md_in1 : md_in1;
    w_b_abs    = w_b_neg ? -md_in2 : md_in2;
    // Remainder follows the dividend; everything else follows the sign product.
    w_neg      = (md_op[2] && md_op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
    w_div0     = md_op[2] && (md_in2 == '0);
    w_ovf      = md_op[2] && !md_op[0] && (md_in1 == c_int_min) && (md_in2 == '1);
    w_special  = '0;
    if (w_div0)
      w_special = md_op[1] ? md_in1 : '1;
    else if (w_ovf)
      w_special = md_op[1] ? '0 : md_in1;
  end

  // One iteration: multiply shifts right through {hi, lo}; divide shifts left.
  always_comb begin
    w_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_opnd : {XLEN{1'b0}})};
    w_shift = r_acc[2*XLEN-1:XLEN-1];
    w_diff  = w_shift - {1'b0, r_opnd};
    if (!r_op[2])
      w_acc_nxt = {w_sum, r_acc[XLEN-1:1]};
    else if (w_diff[XLEN])
      w_acc_nxt = {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
    else
      w_acc_nxt = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
  end

  always_comb begin
    w_prod = r_neg ? -r_acc : r_acc;
    w_res  = '0;
    if (r_bypass)
      w_res = r_acc[XLEN-1:0];
    else if (r_op[2])
      w_res = r_op[1] ? (r_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN])
                      : (r_neg ? -r_acc[XLEN-1:0]      : r_acc[XLEN-1:0]);
    else
      w_res = (r_op == 3'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_bypass <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      md_busy  <= 1'b0;
      md_done  <= 1'b0;
      md_out   <= '0;
    end else begin
      md_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (md_start && !md_kill) begin
            r_op    <= md_op;
            r_neg   <= w_neg;
            md_busy <= 1'b1;
            if (w_div0 || w_ovf) begin
              r_bypass <= 1'b1;
              r_acc    <= {{XLEN{1'b0}}, w_special};
              r_opnd   <= '0;
              r_cnt    <= '0;
              r_state  <= DONE;
            end else begin
              r_bypass <= 1'b0;
              r_acc    <= {{XLEN{1'b0}}, (md_op[2] ? w_a_abs : w_b_abs)};
              r_opnd   <= md_op[2] ? w_b_abs : w_a_abs;
              r_cnt    <= CNT_W'(XLEN);
              r_state  <= CALC;
            end
          end
        end
        CALC: begin
          if (md_kill) begin
            r_state <= IDLE;
            md_busy <= 1'b0;
          end else begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1))
              r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
          md_busy <= 1'b0;
          if (!md_kill) begin
            md_done <= 1'b1;
            md_out  <= w_res;
          end
        end
        default: begin
          r_state <= IDLE;
          md_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_z_core_mul_div.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_z_core_mul_div : scoreboard bench for z_core_mul_div (XLEN 32 and 16).  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_z_core_mul_div;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        md_start = 1'b0, md_kill = 1'b0, md_busy, md_done;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] md_in1 = '0, md_in2 = '0, md_out;

  logic        s16_start = 1'b0, s16_busy, s16_done;
  logic [2:0]  s16_op = 3'd0;
  logic [15:0] s16_in1 = '0, s16_in2 = '0, s16_out;

  z_core_mul_div #(.XLEN(32)) u_dut (
    .clk(clk), .rstn(rstn), .md_start(md_start), .md_op(md_op),
    .md_in1(md_in1), .md_in2(md_in2), .md_kill(md_kill),
    .md_busy(md_busy), .md_done(md_done), .md_out(md_out)
  );

  z_core_mul_div #(.XLEN(16)) u_dut16 (
    .clk(clk), .rstn(rstn), .md_start(s16_start), .md_op(s16_op),
    .md_in1(s16_in1), .md_in2(s16_in2), .md_kill(1'b0),
    .md_busy(s16_busy), .md_done(s16_done), .md_out(s16_out)
  );

  typedef struct {
    logic [31:0] val;
    int          start;
    int          lat;
    string       name;
  } exp_t;

  exp_t q32[$];
  exp_t q16[$];
  int   n_cmp = 0, n_bad = 0, n_done32 = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endfunction

  always @(negedge clk) begin : mon32
    exp_t e;
    if (md_done) begin
      n_done32++;
      if (q32.size() == 0) check("unexpected_done32", 64'(1), 64'(0));
      else begin
        e = q32.pop_front();
        check({e.name, "_val"}, 64'(md_out), 64'(e.val));
        check({e.name, "_lat"}, 64'(cyc - e.start), 64'(e.lat));
      end
    end
  end

  always @(negedge clk) begin : mon16
    exp_t e;
    if (s16_done) begin
      if (q16.size() == 0) check("unexpected_done16", 64'(1), 64'(0));
      else begin
        e = q16.pop_front();
        check({e.name, "_val"}, 64'(s16_out), 64'(e.val));
        check({e.name, "_lat"}, 64'(cyc - e.start), 64'(e.lat));
      end
    end
  end

  task automatic issue32(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] val, input int lat, input bit push);
    @(negedge clk);
    md_start = 1'b1; md_op = op; md_in1 = a; md_in2 = b;
    if (push) q32.push_back('{val, cyc + 1, lat, name});
    @(negedge clk);
    md_start = 1'b0;
  endtask

  task automatic wait32(input string name);
    bit busy_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (q32.size() == 0) break;
      if (!md_busy) busy_ok = 1'b0;
    end
    check({name, "_drained"}, 64'(q32.size()), 64'(0));
    check({name, "_busy"}, 64'(busy_ok), 64'(1));
    q32.delete();
  endtask

  task automatic run32(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] val, input int lat);
    issue32(name, op, a, b, val, lat, 1'b1);
    wait32(name);
  endtask

  task automatic run16(input string name, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] val, input int lat);
    @(negedge clk);
    s16_start = 1'b1; s16_op = op; s16_in1 = a; s16_in2 = b;
    q16.push_back('{{16'h0, val}, cyc + 1, lat, name});
    @(negedge clk);
    s16_start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (q16.size() == 0) break;
    end
    check({name, "_drained"}, 64'(q16.size()), 64'(0));
    q16.delete();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int d;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(md_busy), 64'(0));
    check("rst_done", 64'(md_done), 64'(0));
    check("rst_out",  64'(md_out),  64'(0));
    rstn = 1'b1;

    run32("mul_7x6",     3'd0, 32'd7,        32'd6,        32'd42,       33);
    run32("mul_neg",     3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 33);
    run32("mulhu",       3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run32("mulh",        3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
    run32("mulhsu",      3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
    run32("div_m7_2",    3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run32("rem_m7_2",    3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run32("div_7_m2",    3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33);
    run32("rem_7_m2",    3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        33);
    run32("divu_20_3",   3'd5, 32'd20,       32'd3,        32'd6,        33);
    run32("remu_20_3",   3'd7, 32'd20,       32'd3,        32'd2,        33);
    run32("divu_max_1",  3'd5, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33);
    run32("divu_by0",    3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run32("rem_by0",     3'd6, 32'd5,        32'd0,        32'd5,        1);
    run32("div_ovf",     3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run32("rem_ovf",     3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    // A second request during CALC must be ignored, not queued.
    issue32("ign_start", 3'd0, 32'd7, 32'd6, 32'd42, 33, 1'b1);
    repeat (5) @(negedge clk);
    md_start = 1'b1; md_in1 = 32'd3; md_in2 = 32'd3;
    @(negedge clk);
    md_start = 1'b0;
    wait32("ign_start");

    // Kill ten cycles into a multiply.
    issue32("kill", 3'd0, 32'd123, 32'd456, 32'd0, 0, 1'b0);
    repeat (9) @(negedge clk);
    md_kill = 1'b1;
    @(negedge clk);
    md_kill = 1'b0;
    #1;
    check("kill_busy", 64'(md_busy), 64'(0));
    check("kill_out",  64'(md_out),  64'(42));
    d = n_done32;
    repeat (40) @(negedge clk);
    check("kill_no_done", 64'(n_done32), 64'(d));

    // Asynchronous reset in the middle of a divide.
    issue32("rst_mid", 3'd4, 32'd1000, 32'd3, 32'd0, 0, 1'b0);
    repeat (10) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("midrst_busy", 64'(md_busy), 64'(0));
    check("midrst_done", 64'(md_done), 64'(0));
    check("midrst_out",  64'(md_out),  64'(0));
    @(posedge clk);
    #2 rstn = 1'b1;
    run32("divu_100_7",  3'd5, 32'd100, 32'd7, 32'd14, 33);

    run16("mul16_7x6",   3'd0, 16'd7,    16'd6,    16'd42,    17);
    run16("divu16",      3'd5, 16'hFFFF, 16'h0010, 16'h0FFF, 17);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
